// File: rtl/spi_packet_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : spi_packet_receiver
//  Description : SPI mode-0 slave that receives one frame of WORDS words
//                (destination, data, checksum) of size+1 bits each, presents
//                every completed word on dataIn with a matching write strobe,
//                and closes the frame with sendData or frameError. A small
//                status word (lastErr, lastOk) is shifted out on miso.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_packet_receiver #(
  parameter int size  = 8,
  parameter int WORDS = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sclk,
  input  logic          cs_n,
  input  logic          mosi,
  output logic          miso,
  output logic [size:0] dataIn,
  output logic          writeDes,
  output logic          writeData,
  output logic          writeCheck,
  output logic          sendData,
  output logic          frameError
);

  localparam int c_WORD_BITS = size + 1;
  localparam int c_BCNT_W    = $clog2(c_WORD_BITS + 1);
  localparam int c_WCNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;

  // bitCnt value while the final bit of a word is still outstanding
  localparam logic [c_BCNT_W-1:0] c_BIT_LAST  = c_BCNT_W'(size);
  // bitCnt value once a whole word sits in the shift register
  localparam logic [c_BCNT_W-1:0] c_BIT_FULL  = c_BCNT_W'(c_WORD_BITS);
  localparam logic [c_WCNT_W-1:0] c_WORD_DES  = '0;
  localparam logic [c_WCNT_W-1:0] c_WORD_DATA = c_WCNT_W'(1);
  localparam logic [c_WCNT_W-1:0] c_WORD_LAST = c_WCNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECEIVE  = 2'd1,
    WAIT_END = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronisers and edge detection
  // --------------------------------------------------------------------------
  logic [2:0] sclk_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] mosi_sync_q;
  logic       csRise_q;
  logic       csFall_q;

  logic sclkRise;
  logic sclkFall;
  logic csRiseRaw;
  logic csFallRaw;

  assign sclkRise  =  sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclkFall  = ~sclk_sync_q[1] &  sclk_sync_q[2];
  assign csRiseRaw =  cs_sync_q[1]   & ~cs_sync_q[2];
  assign csFallRaw = ~cs_sync_q[1]   &  cs_sync_q[2];

  // Two-stage synchronisers plus a third stage for edge detection. The chip
  // select chain clears to 0 so that a cs_n held low across reset release
  // never looks like a falling edge; the spurious rise it may show instead
  // lands in IDLE, where rises are ignored. The cs edge pulses get one extra
  // register so frame start/end decisions line up one cycle behind the data
  // sample, matching the word-strobe latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      csRise_q    <= 1'b0;
      csFall_q    <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      cs_sync_q   <= {cs_sync_q[1:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      csRise_q    <= csRiseRaw;
      csFall_q    <= csFallRaw;
    end
  end

  // --------------------------------------------------------------------------
  // Frame state
  // --------------------------------------------------------------------------
  state_t                state_q,      state_d;
  logic [c_BCNT_W-1:0]   bitCnt_q,     bitCnt_d;
  logic [c_WCNT_W-1:0]   wordCnt_q,    wordCnt_d;
  logic [size:0]         shift_q,      shift_d;
  logic [size:0]         dataIn_q,     dataIn_d;
  logic [size:0]         stat_q,       stat_d;
  logic                  writeDes_q,   writeDes_d;
  logic                  writeData_q,  writeData_d;
  logic                  writeCheck_q, writeCheck_d;
  logic                  sendData_q,   sendData_d;
  logic                  frameError_q, frameError_d;
  logic                  lastOk_q,     lastOk_d;
  logic                  lastErr_q,    lastErr_d;
  logic                  overrun_q,    overrun_d;
  logic                  endPend_q,    endPend_d;

  logic wordDone;
  logic lastWord;
  logic finalBit;

  assign wordDone = (bitCnt_q == c_BIT_FULL);
  assign lastWord = (wordCnt_q == c_WORD_LAST);
  assign finalBit = sclkRise && (bitCnt_q == c_BIT_LAST) && lastWord;

  // State register and all registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      wordCnt_q    <= '0;
      shift_q      <= '0;
      dataIn_q     <= '0;
      stat_q       <= '0;
      writeDes_q   <= 1'b0;
      writeData_q  <= 1'b0;
      writeCheck_q <= 1'b0;
      sendData_q   <= 1'b0;
      frameError_q <= 1'b0;
      lastOk_q     <= 1'b0;
      lastErr_q    <= 1'b0;
      overrun_q    <= 1'b0;
      endPend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitCnt_q     <= bitCnt_d;
      wordCnt_q    <= wordCnt_d;
      shift_q      <= shift_d;
      dataIn_q     <= dataIn_d;
      stat_q       <= stat_d;
      writeDes_q   <= writeDes_d;
      writeData_q  <= writeData_d;
      writeCheck_q <= writeCheck_d;
      sendData_q   <= sendData_d;
      frameError_q <= frameError_d;
      lastOk_q     <= lastOk_d;
      lastErr_q    <= lastErr_d;
      overrun_q    <= overrun_d;
      endPend_q    <= endPend_d;
    end
  end

  // Next-state logic: frame sequencing, word capture and status shifting
  always_comb begin
    state_d      = state_q;
    bitCnt_d     = bitCnt_q;
    wordCnt_d    = wordCnt_q;
    shift_d      = shift_q;
    dataIn_d     = dataIn_q;
    stat_d       = stat_q;
    writeDes_d   = 1'b0;
    writeData_d  = 1'b0;
    writeCheck_d = 1'b0;
    sendData_d   = 1'b0;
    frameError_d = 1'b0;
    lastOk_d     = lastOk_q;
    lastErr_d    = lastErr_q;
    overrun_d    = overrun_q;
    endPend_d    = endPend_q;

    // Status word moves out MSB first while a frame is open
    if (state_q != IDLE && sclkFall) begin
      stat_d = {stat_q[size-1:0], 1'b0};
    end

    case (state_q)
      IDLE: begin
        if (csFall_q) begin
          state_d   = RECEIVE;
          bitCnt_d  = '0;
          wordCnt_d = '0;
          overrun_d = 1'b0;
          endPend_d = 1'b0;
          stat_d    = {{(size-1){1'b0}}, lastErr_q, lastOk_q};
        end
      end

      RECEIVE: begin
        if (sclkRise) begin
          shift_d  = {shift_q[size-1:0], mosi_sync_q[1]};
          bitCnt_d = bitCnt_q + c_BCNT_W'(1);
        end

        if (wordDone) begin
          dataIn_d  = shift_q;
          bitCnt_d  = '0;
          wordCnt_d = wordCnt_q + c_WCNT_W'(1);
          if (wordCnt_q == c_WORD_LAST) begin
            writeCheck_d = 1'b1;
            state_d      = WAIT_END;
          end else if (wordCnt_q == c_WORD_DES) begin
            writeDes_d = 1'b1;
          end else if (wordCnt_q == c_WORD_DATA) begin
            writeData_d = 1'b1;
          end else begin
            writeCheck_d = 1'b0;
          end
        end

        if (csRise_q) begin
          if (lastWord && (wordDone || finalBit)) begin
            // Chip select rose together with the final bit: finish the word
            // first and close the frame from WAIT_END.
            endPend_d = 1'b1;
          end else begin
            // Short frame: a word completing in this very cycle is dropped so
            // the error pulse stays the only strobe and dataIn is untouched.
            dataIn_d     = dataIn_q;
            writeDes_d   = 1'b0;
            writeData_d  = 1'b0;
            writeCheck_d = 1'b0;
            frameError_d = 1'b1;
            lastErr_d    = 1'b1;
            lastOk_d     = 1'b0;
            state_d      = IDLE;
          end
        end
      end

      WAIT_END: begin
        if (sclkRise) begin
          overrun_d = 1'b1;
        end
        if (csRise_q || endPend_q) begin
          if (overrun_q) begin
            frameError_d = 1'b1;
            lastErr_d    = 1'b1;
            lastOk_d     = 1'b0;
          end else begin
            sendData_d = 1'b1;
            lastOk_d   = 1'b1;
            lastErr_d  = 1'b0;
          end
          endPend_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign miso       = (state_q != IDLE) && stat_q[size];
  assign dataIn     = dataIn_q;
  assign writeDes   = writeDes_q;
  assign writeData  = writeData_q;
  assign writeCheck = writeCheck_q;
  assign sendData   = sendData_q;
  assign frameError = frameError_q;

endmodule
`default_nettype wire
